// File: rtl/cpe_column_sequencer_if.sv
// Bus between the column sequencer and its environment: job control,
// compensation memory read port, CPE column controls and the result path.
interface cpe_column_sequencer_if #(
  parameter int ROWS                           = 8,
  parameter int COMPENSATION_PARTIAL_SUM_WIDTH = 14,
  parameter int ADDR_WIDTH                     = 6
);
  logic                                      start;
  logic [7:0]                                num_vectors;
  logic [ADDR_WIDTH-1:0]                     base_addr;
  logic                                      busy;
  logic                                      done;
  logic                                      mem_rd_en;
  logic [ADDR_WIDTH-1:0]                     mem_rd_addr;
  logic [3:0]                                mem_rd_data;
  logic [3:0]                                Compensation_Weight;
  logic                                      Compensation_Weight_out_valid;
  logic                                      act_req;
  logic [ROWS-1:0]                           Activation_cout_valid;
  logic [COMPENSATION_PARTIAL_SUM_WIDTH-1:0] result_in;
  logic                                      result_valid;
  logic [COMPENSATION_PARTIAL_SUM_WIDTH-1:0] result_out;

  // Sequencer side.
  modport master (
    input  start, num_vectors, base_addr, mem_rd_data, result_in,
    output busy, done, mem_rd_en, mem_rd_addr, Compensation_Weight,
           Compensation_Weight_out_valid, act_req, Activation_cout_valid,
           result_valid, result_out
  );

  // Environment side (job issuer, memory, feeder, column).
  modport slave (
    output start, num_vectors, base_addr, mem_rd_data, result_in,
    input  busy, done, mem_rd_en, mem_rd_addr, Compensation_Weight,
           Compensation_Weight_out_valid, act_req, Activation_cout_valid,
           result_valid, result_out
  );
endinterface

// File: rtl/cpe_column_sequencer.sv
// Column sequencer: preloads ROWS weights bottom-row-first, streams
// num_vectors activations with a per-row skewed valid, then waits for the
// bottom-row results to be emitted before pulsing done.
module cpe_column_sequencer #(
  parameter int ROWS                           = 8,
  parameter int COMPENSATION_PARTIAL_SUM_WIDTH = 14,
  parameter int ADDR_WIDTH                     = 6
) (
  input logic                    clk,
  input logic                    rst,
  cpe_column_sequencer_if.master io
);
  localparam int LCW = $clog2(ROWS + 1);
  localparam int W   = COMPENSATION_PARTIAL_SUM_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STREAM, S_DRAIN, S_FIN} state_t;

  state_t                state_q, state_d;
  logic [7:0]            nv_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [LCW-1:0]        lcnt_q;
  logic [7:0]            vcnt_q, rcnt_q;
  logic                  wv_q;
  logic [ROWS-1:0]       acv_q;   // skewed MAC enables, bit r = row r
  logic                  cap_q;   // bottom row output valid this cycle
  logic                  rv_q;
  logic [W-1:0]          res_q;
  logic                  rd_en, act;

  // Next-state and phase strobes. LOAD lasts ROWS+1 cycles so the final
  // weight-valid cycle (one after the last read) is still inside LOAD.
  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    act     = 1'b0;
    case (state_q)
      S_IDLE:   if (io.start) state_d = S_LOAD;
      S_LOAD: begin
        rd_en = (lcnt_q != LCW'(ROWS));
        if (!rd_en) state_d = (nv_q == 8'd0) ? S_DRAIN : S_STREAM;
      end
      S_STREAM: begin
        act = 1'b1;
        if (vcnt_q == nv_q - 8'd1) state_d = S_DRAIN;
      end
      S_DRAIN:  if (rcnt_q == nv_q) state_d = S_FIN;
      S_FIN:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State, job registers, counters and the valid delay lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      nv_q    <= '0;
      base_q  <= '0;
      lcnt_q  <= '0;
      vcnt_q  <= '0;
      rcnt_q  <= '0;
      wv_q    <= 1'b0;
      acv_q   <= '0;
      cap_q   <= 1'b0;
      rv_q    <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && io.start) begin
        nv_q   <= io.num_vectors;
        base_q <= io.base_addr;
        lcnt_q <= '0;
        vcnt_q <= '0;
        rcnt_q <= '0;
      end else begin
        if (rd_en) lcnt_q <= lcnt_q + LCW'(1);
        if (act)   vcnt_q <= vcnt_q + 8'd1;
        // Counted at capture so DRAIN sees the total in the last result cycle.
        if (cap_q) rcnt_q <= rcnt_q + 8'd1;
      end
      wv_q  <= rd_en;
      acv_q <= {acv_q[ROWS-2:0], act};
      cap_q <= acv_q[ROWS-1];
      rv_q  <= cap_q;
      if (cap_q) res_q <= io.result_in;
    end
  end

  // Output drive; the weight is gated so it reads 0 outside valid cycles.
  always_comb begin
    io.busy                          = (state_q != S_IDLE);
    io.done                          = (state_q == S_FIN);
    io.mem_rd_en                     = rd_en;
    io.mem_rd_addr                   = rd_en ? base_q + ADDR_WIDTH'(ROWS - 1)
                                               - ADDR_WIDTH'(lcnt_q) : '0;
    io.Compensation_Weight_out_valid = wv_q;
    io.Compensation_Weight           = wv_q ? io.mem_rd_data : 4'h0;
    io.act_req                       = act;
    io.Activation_cout_valid         = acv_q;
    io.result_valid                  = rv_q;
    io.result_out                    = res_q;
  end
endmodule

// File: tb/tb_cpe_column_sequencer.sv
// Bench for cpe_column_sequencer: directed jobs, a cycle-timing model derived
// from the job start cycle, and a few hand-computed literal checks.
module tb_cpe_column_sequencer;
  localparam int ROWS = 8;
  localparam int W    = 14;
  localparam int AW   = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpe_column_sequencer_if #(.ROWS(ROWS), .COMPENSATION_PARTIAL_SUM_WIDTH(W),
                            .ADDR_WIDTH(AW)) bus();

  cpe_column_sequencer #(.ROWS(ROWS), .COMPENSATION_PARTIAL_SUM_WIDTH(W),
                         .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  // Model state: a job is fully described by its start cycle, N and base.
  int   cyc   = 0;
  bit   m_act = 1'b0;
  int   js = 0, jn = 0, jb = 0;
  bit   rst_q = 1'b1;
  int   scen  = 0;
  int   nvec  = 0, nmis = 0;
  logic [W-1:0] exp_res = '0;

  function automatic logic [3:0] memv(input int a);
    return 4'(a & 15);
  endfunction

  function automatic logic [W-1:0] rin(input int c);
    return W'(c * 613 + 91);
  endfunction

  function automatic int done_rel(input int n);
    return (n == 0) ? ROWS + 3 : 2 * ROWS + n + 4;
  endfunction

  function automatic bit in_rng(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

  function automatic bit model_busy(input int c);
    return m_act && in_rng(c - js, 1, done_rel(jn));
  endfunction

  // Job acceptance: a start counts only when the job model says not busy.
  always @(posedge clk) begin
    rst_q <= rst;
    if (rst) m_act <= 1'b0;
    else if (bus.start && !model_busy(cyc)) begin
      m_act <= 1'b1;
      js    <= cyc;
      jn    <= int'(bus.num_vectors);
      jb    <= int'(bus.base_addr);
    end
    cyc <= cyc + 1;
  end

  // Compensation memory: data one cycle after the read strobe.
  initial begin
    logic          en;
    logic [AW-1:0] ad;
    bus.mem_rd_data = 4'h0;
    forever begin
      @(negedge clk);
      en = bus.mem_rd_en;
      ad = bus.mem_rd_addr;
      @(posedge clk);
      #1;
      bus.mem_rd_data = en ? memv(int'(ad)) : 4'h0;
    end
  end

  // Bottom CPE output: a distinct value every cycle exposes the capture cycle.
  initial begin
    bus.result_in = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.result_in = rin(cyc);
    end
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nmis++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, a, e);
    end
  endtask

  // Per-cycle compare against the model, plus literal pins per scenario.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      int rel, dr;
      bit e_busy, e_done, e_rd, e_wv, e_act, e_rv;
      logic [AW-1:0]   e_addr;
      logic [3:0]      e_w;
      logic [ROWS-1:0] e_acv;
      rel    = cyc - js;
      dr     = done_rel(jn);
      e_busy = m_act && in_rng(rel, 1, dr);
      e_done = m_act && (rel == dr);
      e_rd   = m_act && in_rng(rel, 1, ROWS);
      e_wv   = m_act && in_rng(rel, 2, ROWS + 1);
      e_act  = m_act && jn > 0 && in_rng(rel, ROWS + 2, ROWS + 1 + jn);
      e_rv   = m_act && jn > 0 && in_rng(rel, 2 * ROWS + 4, 2 * ROWS + jn + 3);
      e_addr = e_rd ? AW'((jb + ROWS - rel) & 63) : '0;
      e_w    = e_wv ? memv((jb + ROWS + 1 - rel) & 63) : 4'h0;
      for (int r = 0; r < ROWS; r++)
        e_acv[r] = m_act && jn > 0 && in_rng(rel, ROWS + 3 + r, ROWS + 2 + jn + r);
      if (rst_q) exp_res = '0;
      if (e_rv)  exp_res = rin(cyc - 1);

      chk("busy",   32'(bus.busy),                          32'(e_busy));
      chk("done",   32'(bus.done),                          32'(e_done));
      chk("rd_en",  32'(bus.mem_rd_en),                     32'(e_rd));
      chk("addr",   32'(bus.mem_rd_addr),                   32'(e_addr));
      chk("wvalid", 32'(bus.Compensation_Weight_out_valid), 32'(e_wv));
      chk("weight", 32'(bus.Compensation_Weight),           32'(e_w));
      chk("actreq", 32'(bus.act_req),                       32'(e_act));
      chk("acv",    32'(bus.Activation_cout_valid),         32'(e_acv));
      chk("rvalid", 32'(bus.result_valid),                  32'(e_rv));
      chk("result", 32'(bus.result_out),                    32'(exp_res));

      if (m_act) begin
        case (scen)
          1: begin
            if (rel == 1)  chk("pin_addr_first", 32'(bus.mem_rd_addr), 32'd7);
            if (rel == 8)  chk("pin_addr_last",  32'(bus.mem_rd_addr), 32'd0);
            if (rel == 2)  chk("pin_w_first",    32'(bus.Compensation_Weight), 32'd7);
            if (rel == 10) chk("pin_act_first",  32'(bus.act_req), 32'd1);
            if (rel == 20) chk("pin_rv_first",   32'(bus.result_valid), 32'd1);
            if (rel == 24) chk("pin_done",       32'(bus.done), 32'd1);
            if (rel == 25) chk("pin_idle",       32'(bus.busy), 32'd0);
          end
          2: begin
            if (rel == 11) chk("pin_acv_row0", 32'(bus.Activation_cout_valid), 32'h01);
            if (rel == 18) chk("pin_acv_row7", 32'(bus.Activation_cout_valid), 32'h80);
            if (rel == 20) chk("pin_rv_n1",    32'(bus.result_valid), 32'd1);
          end
          3: if (rel == 11) chk("pin_done_n0", 32'(bus.done), 32'd1);
          4: begin
            if (rel == 4) chk("pin_wrap0",  32'(bus.mem_rd_addr), 32'd0);
            if (rel == 5) chk("pin_wrap63", 32'(bus.mem_rd_addr), 32'd63);
            if (rel == 8) chk("pin_wrap60", 32'(bus.mem_rd_addr), 32'd60);
          end
          default: ;
        endcase
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents start for one cycle, then scrambles the job inputs so any
  // late relatch shows up as wrong timing or addresses.
  task automatic go(input int n, input int b);
    bus.start       = 1'b1;
    bus.num_vectors = 8'(n);
    bus.base_addr   = AW'(b);
    step(1);
    bus.start       = 1'b0;
    bus.num_vectors = 8'hA5;
    bus.base_addr   = AW'(37);
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.num_vectors = '0;
    bus.base_addr   = '0;
    step(3);
    rst = 1'b0;
    step(2);

    scen = 1; go(4, 0);  step(30);
    scen = 2; go(1, 0);  step(25);
    scen = 3; go(0, 0);  step(15);
    scen = 4; go(2, 60); step(25);

    // start during STREAM (rel 11) and in FIN (rel 23), then right after.
    scen = 5; go(3, 5);  step(10);
    bus.start = 1'b1; bus.num_vectors = 8'd9; bus.base_addr = AW'(33);
    step(1);
    bus.start = 1'b0;
    step(11);
    bus.start = 1'b1; bus.num_vectors = 8'd1; bus.base_addr = AW'(10);
    step(2);
    bus.start = 1'b0;
    step(25);

    // Reset in cycle 12 of an N=4 job, then a fresh job.
    scen = 6; go(4, 0);  step(11);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(20);
    scen = 1; go(4, 0);  step(30);

    scen = 7; go(255, 17); step(ROWS * 2 + 255 + 10);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/cpe_column_sequencer.md
Name: cpe_column_sequencer

Overview:
- Sequences one column of ROWS chained CPE compensation elements.
- Three phases per job:
  - Preload: fetch ROWS 4-bit compensation weights from compensation memory and shift them down the column's weight-pass chain.
  - Stream: issue num_vectors activation vectors with a one-cycle-per-row skewed valid.
  - Drain: collect the bottom-row compensation outputs.
- Sits between the compensation memory/activation feeder and the CPE column. Pulses done when the last result has been emitted.

Parameters:
- ROWS, 8, number of CPEs in the column (≥2).
- COMPENSATION_PARTIAL_SUM_WIDTH, 14, width of the column result.
- ADDR_WIDTH, 6, compensation memory address width.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  job request; sampled only in IDLE.
- num_vectors  in  8  activation vectors in the job; latched at start.
- base_addr  in  ADDR_WIDTH  first weight address; latched at start.
- busy  out  1  high from the cycle after start is accepted through the done cycle.
- done  out  1  one-cycle pulse at job end.
- mem_rd_en  out  1  compensation memory read strobe.
- mem_rd_addr  out  ADDR_WIDTH  read address.
- mem_rd_data  in  4  read data; valid exactly 1 cycle after mem_rd_en.
- Compensation_Weight  out  4  weight into the top CPE.
- Compensation_Weight_out_valid  out  1  weight shift enable, broadcast to all CPEs.
- act_req  out  1  activation feeder request; the feeder returns the vector 1 cycle later.
- Activation_cout_valid  out  ROWS  per-row MAC enable; bit r is for CPE row r.
- result_in  in  COMPENSATION_PARTIAL_SUM_WIDTH  Compensation_out of the bottom CPE.
- result_valid  out  1  result_out holds a valid result.
- result_out  out  COMPENSATION_PARTIAL_SUM_WIDTH  registered column result.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, all counters and delay lines 0. Applies mid-job too: the job is abandoned, no done pulse, and no partial results are emitted after reset.
- FSM states: IDLE, LOAD, STREAM, DRAIN, FIN.
- IDLE:
  - start=1 latches num_vectors and base_addr, goes to LOAD, busy=1 next cycle.
  - start while not IDLE is ignored.
- LOAD:
  - mem_rd_en=1 for exactly ROWS consecutive cycles.
  - mem_rd_addr = base_addr+ROWS-1 descending to base_addr, so the bottom row's weight is pushed first. Addresses wrap modulo 2^ADDR_WIDTH.
  - Compensation_Weight_out_valid = mem_rd_en delayed 1 cycle; Compensation_Weight = mem_rd_data in the same cycle.
  - Exactly ROWS valid cycles.
  - After the last valid cycle: go to STREAM, or to DRAIN if num_vectors=0.
- STREAM:
  - act_req=1 for exactly num_vectors cycles, starting the cycle after the last weight-valid cycle.
  - Weight-valid and any Activation_cout_valid bit are never high in the same cycle.
  - Activation_cout_valid[0] = act_req delayed 1; Activation_cout_valid[r] = Activation_cout_valid[r-1] delayed 1.
- Result capture:
  - Capture strobe = Activation_cout_valid[ROWS-1] delayed 1; result_in is sampled on this strobe.
  - result_out and result_valid update 1 cycle after the strobe, so result_valid is high for one cycle per vector, in vector order.
  - result_out holds its last value when result_valid=0.
- DRAIN:
  - Waits until the emitted-result count equals num_vectors, then goes to FIN.
  - With num_vectors=0, goes to FIN immediately.
- FIN: done=1 and busy=1 for one cycle, then IDLE.
- A start asserted in the FIN cycle is ignored. A start in the following cycle is accepted.
- Timing, with start sampled at cycle 0 and N=num_vectors:
  - mem_rd_en: cycles 1..ROWS.
  - weight-valid: cycles 2..ROWS+1.
  - act_req: cycles ROWS+2..ROWS+1+N.
  - result_valid: cycles 2ROWS+4..2ROWS+N+3.
  - done: cycle 2ROWS+N+4 (N≥1); cycle ROWS+3 when N=0.
- Counters:
  - Load counter: ceil(log2(ROWS+1)) bits.
  - Vector-issue and result counters: 8 bits each. N=255 must not overflow.

Test Plan:
- ROWS=8, base_addr=0, mem[i]=i, start, N=4:
  - mem_rd_addr 7,6,…,0 on cycles 1–8.
  - Weight values 7..0 on cycles 2–9; CPE row r ends holding weight r.
  - act_req cycles 10–13; result_valid cycles 20–23; done cycle 24; busy cycles 1–24.
- Skew check, N=1:
  - Activation_cout_valid bit r high only at cycle 11+r.
  - Exactly one result_valid at cycle 20.
- num_vectors=0:
  - 8 loads, no act_req, no result_valid, done at cycle 11.
- base_addr=60, ADDR_WIDTH=6:
  - Addresses 3,2,1,0,63,62,61,60.
- start pulsed during STREAM and in the FIN cycle:
  - Ignored; latched N and addr unchanged.
  - Second start one cycle after done is accepted, with LOAD starting next cycle.
- rst asserted at cycle 12 of an N=4 job:
  - Next cycle: all outputs 0, IDLE.
  - No result_valid or done afterwards.
  - A fresh job then meets the first scenario's timing relative to its start.
